// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//   Parametrised UART receiver. The asynchronous serial line is brought into
//   the i_Clk domain through a two-flop synchroniser. The receiver detects the
//   falling start edge and confirms the start bit at its midpoint, which
//   rejects short glitches. It then samples the data bits (LSB first), an
//   optional parity bit and one or two stop bits, each at the middle of its
//   bit cell. The received word and its error flags are presented together
//   with a one-cycle valid pulse.
//
// Parameters
//   g_System_Clk : system clock frequency in Hz
//   g_Baud_Rate  : line rate in bit/s, clocks per bit = g_System_Clk/g_Baud_Rate
//   g_Data_Bits  : data bits per frame (5..9)
//   g_Parity     : 0 none, 1 odd, 2 even
//   g_Stop_Bits  : 1 or 2
//
// Ports
//   i_Clk        : system clock, rising edge
//   i_Rst        : asynchronous active-high reset
//   i_RX         : serial input, idle high, asynchronous to i_Clk
//   o_RX_DV      : one-cycle pulse, word and flags valid
//   o_RX_Byte    : received word, held until the next valid pulse
//   o_Parity_Err : parity mismatch on the last word (always 0 without parity)
//   o_Frame_Err  : a stop-bit sample was 0 on the last word
//   o_Busy       : receiver is inside a frame or waiting out a line break
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int g_System_Clk = 100_000_000,
  parameter int g_Baud_Rate  = 9600,
  parameter int g_Data_Bits  = 8,
  parameter int g_Parity     = 0,
  parameter int g_Stop_Bits  = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_RX,
  output logic                   o_RX_DV,
  output logic [g_Data_Bits-1:0] o_RX_Byte,
  output logic                   o_Parity_Err,
  output logic                   o_Frame_Err,
  output logic                   o_Busy
);

  localparam int c_CPB  = g_System_Clk / g_Baud_Rate;
  localparam int c_HALF = (c_CPB - 1) / 2;
  localparam int c_CW   = $clog2(c_CPB);

  localparam logic [c_CW-1:0] c_CNT_MID  = c_CW'(c_HALF);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_CPB - 1);
  localparam logic [c_CW-1:0] c_CNT_ZERO = {c_CW{1'b0}};
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [3:0]      c_LAST_DATA = 4'(g_Data_Bits - 1);
  localparam logic [3:0]      c_LAST_STOP = 4'(g_Stop_Bits - 1);
  localparam logic            c_HAS_PAR   = (g_Parity != 0);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_DATA       = 3'd2,
    S_PARITY     = 3'd3,
    S_STOP       = 3'd4,
    S_DONE       = 3'd5,
    S_BREAK_WAIT = 3'd6
  } t_state;

  // Parity check of a complete word against the received parity bit.
  // Odd parity: the XOR over data and parity bit must be 1.
  // Even parity: the XOR over data and parity bit must be 0.
  function automatic logic f_parity_err(input logic [g_Data_Bits-1:0] data,
                                        input logic                   pbit);
    logic w_x;
    w_x = ^{data, pbit};
    if (g_Parity == 1) begin
      return ~w_x;
    end else if (g_Parity == 2) begin
      return w_x;
    end else begin
      return 1'b0;
    end
  endfunction

  // Registers
  logic                   r_sync1;
  logic                   r_rx_s;
  t_state                 r_state;
  logic [c_CW-1:0]        r_cnt;
  logic [3:0]             r_bit_cnt;
  logic [g_Data_Bits-1:0] r_shift;
  logic                   r_par_err;
  logic                   r_stop_err;
  logic                   r_last_stop;
  logic                   r_dv;
  logic [g_Data_Bits-1:0] r_byte;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_busy;

  // Next-state values
  t_state                 w_state_nxt;
  logic [c_CW-1:0]        w_cnt_nxt;
  logic [3:0]             w_bit_cnt_nxt;
  logic [g_Data_Bits-1:0] w_shift_nxt;
  logic                   w_par_err_nxt;
  logic                   w_stop_err_nxt;
  logic                   w_last_stop_nxt;
  logic                   w_dv_nxt;
  logic [g_Data_Bits-1:0] w_byte_nxt;
  logic                   w_perr_nxt;
  logic                   w_ferr_nxt;
  logic                   w_busy_nxt;

  // Two-flop synchroniser for the asynchronous serial line (resets to idle-high)
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= i_RX;
      r_rx_s  <= r_sync1;
    end
  end

  // Receiver state, counters, shift register and registered outputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= c_CNT_ZERO;
      r_bit_cnt   <= 4'd0;
      r_shift     <= {g_Data_Bits{1'b0}};
      r_par_err   <= 1'b0;
      r_stop_err  <= 1'b0;
      r_last_stop <= 1'b1;
      r_dv        <= 1'b0;
      r_byte      <= {g_Data_Bits{1'b0}};
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_par_err   <= w_par_err_nxt;
      r_stop_err  <= w_stop_err_nxt;
      r_last_stop <= w_last_stop_nxt;
      r_dv        <= w_dv_nxt;
      r_byte      <= w_byte_nxt;
      r_perr      <= w_perr_nxt;
      r_ferr      <= w_ferr_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state and output decode for the frame receiver
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_par_err_nxt   = r_par_err;
    w_stop_err_nxt  = r_stop_err;
    w_last_stop_nxt = r_last_stop;
    w_dv_nxt        = 1'b0;
    w_byte_nxt      = r_byte;
    w_perr_nxt      = r_perr;
    w_ferr_nxt      = r_ferr;

    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          // Falling edge: open a new frame with clean error accumulators
          w_state_nxt    = S_START;
          w_cnt_nxt      = c_CNT_ZERO;
          w_bit_cnt_nxt  = 4'd0;
          w_par_err_nxt  = 1'b0;
          w_stop_err_nxt = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_START: begin
        if (r_cnt == c_CNT_MID) begin
          w_cnt_nxt = c_CNT_ZERO;
          // Line high again at mid start bit means the edge was a glitch
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      S_DATA: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt   = c_CNT_ZERO;
          // LSB arrives first, so shift in from the top
          w_shift_nxt = {r_rx_s, r_shift[g_Data_Bits-1:1]};
          if (r_bit_cnt == c_LAST_DATA) begin
            w_bit_cnt_nxt = 4'd0;
            if (c_HAS_PAR) begin
              w_state_nxt = S_PARITY;
            end else begin
              w_state_nxt = S_STOP;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      S_PARITY: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt     = c_CNT_ZERO;
          w_par_err_nxt = f_parity_err(r_shift, r_rx_s);
          w_state_nxt   = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      S_STOP: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt = c_CNT_ZERO;
          if (!r_rx_s) begin
            w_stop_err_nxt = 1'b1;
          end else begin
            w_stop_err_nxt = r_stop_err;
          end
          if (r_bit_cnt == c_LAST_STOP) begin
            // Final stop sample: publish the word now rather than waiting
            // for the end of the stop bit, so a back-to-back start edge
            // is seen on time.
            w_bit_cnt_nxt   = 4'd0;
            w_state_nxt     = S_DONE;
            w_dv_nxt        = 1'b1;
            w_byte_nxt      = r_shift;
            w_perr_nxt      = r_par_err;
            w_ferr_nxt      = r_stop_err | ~r_rx_s;
            w_last_stop_nxt = r_rx_s;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      S_DONE: begin
        // A low final stop sample may be a break; wait for the line to
        // recover before looking for another start edge.
        if (r_last_stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BREAK_WAIT;
        end
      end

      S_BREAK_WAIT: begin
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BREAK_WAIT;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = c_CNT_ZERO;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign o_RX_DV      = r_dv;
  assign o_RX_Byte    = r_byte;
  assign o_Parity_Err = c_HAS_PAR ? r_perr : 1'b0;
  assign o_Frame_Err  = r_ferr;
  assign o_Busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg. Three receivers with different frame
// formats share clock and reset: id0 = 8 data / even parity / 1 stop,
// id1 = 7 data / odd parity / 2 stop, id2 = 8N1. Each frame sent pushes its
// expected word, flags and nominal valid cycle; a monitor pops on every
// o_RX_DV and compares.
module tb_uart_rx_cfg;

  localparam int CPB  = 16;           // 100 MHz / 6.25 Mbaud
  localparam int HALF = (CPB - 1) / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx  = 3'b111;

  logic [2:0] dv, perr, ferr, busy;
  logic [7:0] byte_a, byte_c;
  logic [6:0] byte_b;

  int nb[3] = '{8, 7, 8};
  int pm[3] = '{2, 1, 0};
  int ns[3] = '{1, 2, 1};

  typedef struct {
    int          id;
    logic [8:0]  data;
    logic        perr;
    logic        ferr;
    longint      cyc;
  } exp_t;

  exp_t   sb[$];
  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  logic [2:0] prev_dv = 3'b000;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.g_System_Clk(100_000_000), .g_Baud_Rate(6_250_000),
                .g_Data_Bits(8), .g_Parity(2), .g_Stop_Bits(1)) u_a (
    .i_Clk(clk), .i_Rst(rst), .i_RX(rx[0]), .o_RX_DV(dv[0]), .o_RX_Byte(byte_a),
    .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]), .o_Busy(busy[0]));

  uart_rx_cfg #(.g_System_Clk(100_000_000), .g_Baud_Rate(6_250_000),
                .g_Data_Bits(7), .g_Parity(1), .g_Stop_Bits(2)) u_b (
    .i_Clk(clk), .i_Rst(rst), .i_RX(rx[1]), .o_RX_DV(dv[1]), .o_RX_Byte(byte_b),
    .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]), .o_Busy(busy[1]));

  uart_rx_cfg #(.g_System_Clk(100_000_000), .g_Baud_Rate(6_250_000),
                .g_Data_Bits(8), .g_Parity(0), .g_Stop_Bits(1)) u_c (
    .i_Clk(clk), .i_Rst(rst), .i_RX(rx[2]), .o_RX_DV(dv[2]), .o_RX_Byte(byte_c),
    .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]), .o_Busy(busy[2]));

  function automatic logic [8:0] get_byte(input int id);
    if (id == 0)      return {1'b0, byte_a};
    else if (id == 1) return {2'b00, byte_b};
    else              return {1'b0, byte_c};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] mask_data(input int id, input logic [8:0] d);
    logic [8:0] m;
    m = 9'((1 << nb[id]) - 1);
    return d & m;
  endfunction

  // Parity bit that makes the frame correct for this receiver's mode
  function automatic logic good_par(input int id, input logic [8:0] d);
    int ones;
    ones = $countones(mask_data(id, d));
    if (pm[id] == 1) return (ones % 2 == 0);
    else             return (ones % 2 == 1);
  endfunction

  // Reference model: expected word, flags and nominal valid cycle of a frame
  function automatic exp_t model(input int id, input logic [8:0] d, input logic pbit,
                                 input logic [1:0] stops, input longint start);
    exp_t e;
    int   ones, bits;
    e.id   = id;
    e.data = mask_data(id, d);
    ones   = $countones(e.data) + ((pm[id] != 0) ? int'(pbit) : 0);
    if (pm[id] == 1)      e.perr = (ones % 2 == 0);
    else if (pm[id] == 2) e.perr = (ones % 2 == 1);
    else                  e.perr = 1'b0;
    e.ferr = !stops[0] || (ns[id] == 2 && !stops[1]);
    bits   = nb[id] + ((pm[id] != 0) ? 1 : 0) + ns[id];
    e.cyc  = start + 2 + HALF + longint'(CPB) * bits + 1;
    return e;
  endfunction

  task automatic hold(input int id, input logic v, input int cycles);
    rx[id] = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Sends one frame; the line is left at the value of the last stop bit
  task automatic send_frame(input int id, input logic [8:0] d, input logic pbit,
                            input logic [1:0] stops);
    sb.push_back(model(id, d, pbit, stops, cyc));
    hold(id, 1'b0, CPB);
    for (int i = 0; i < nb[id]; i++) hold(id, d[i], CPB);
    if (pm[id] != 0) hold(id, pbit, CPB);
    for (int i = 0; i < ns[id]; i++) hold(id, stops[i], CPB);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_missing_dv", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Monitor: every valid pulse is matched against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (dv[i]) begin
          chk("dv_single_cycle", 64'(prev_dv[i]), 64'd0);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_dv id=%0d byte=%0h (t=%0t)", i, get_byte(i), $time);
          end else begin
            e = sb.pop_front();
            chk("dv_id", 64'(i), 64'(e.id));
            chk("rx_byte", 64'(get_byte(i)), 64'(e.data));
            chk("parity_err", 64'(perr[i]), 64'(e.perr));
            chk("frame_err", 64'(ferr[i]), 64'(e.ferr));
            checks++;
            if (cyc < e.cyc - 2 || cyc > e.cyc + 2) begin
              failures++;
              $display("FAIL dv_latency actual_cycle=%0d expected_cycle=%0d", cyc, e.cyc);
            end
          end
        end
      end
    end
    prev_dv = dv;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    longint k;
    logic [8:0] d;
    logic       p;
    logic [1:0] st;
    int         id;

    rx  = 3'b111;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_dv", 64'(dv[i]), 64'd0);
      chk("reset_byte", 64'(get_byte(i)), 64'd0);
      chk("reset_flags", 64'({perr[i], ferr[i], busy[i]}), 64'd0);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 8N1 basic frame
    send_frame(2, 9'h0AA, 1'b0, 2'b11);
    hold(2, 1'b1, CPB);
    chk("busy_after_dv_8n1", 64'(busy[2]), 64'd0);
    drain();

    // Even parity: correct and wrong parity bit
    send_frame(0, 9'h037, 1'b1, 2'b11);
    hold(0, 1'b1, CPB);
    send_frame(0, 9'h037, 1'b0, 2'b11);
    hold(0, 1'b1, CPB);
    drain();

    // Break: stop bit low, line held low three more bit periods
    send_frame(2, 9'h055, 1'b0, 2'b10);
    hold(2, 1'b0, 3 * CPB);
    chk("busy_during_break", 64'(busy[2]), 64'd1);
    hold(2, 1'b1, 6);
    chk("busy_after_break", 64'(busy[2]), 64'd0);
    hold(2, 1'b1, CPB);
    drain();

    // Glitch of a quarter bit period, then a real frame
    k = cyc;
    hold(2, 1'b0, CPB / 4);
    rx[2] = 1'b1;
    while (cyc < k + 2 + CPB / 2 + 3) @(posedge clk);
    #1;
    chk("busy_after_glitch", 64'(busy[2]), 64'd0);
    hold(2, 1'b1, CPB);
    send_frame(2, 9'h03C, 1'b0, 2'b11);
    hold(2, 1'b1, CPB);
    drain();

    // 7 data bits, 2 stop bits, back-to-back frames
    send_frame(1, 9'h001, good_par(1, 9'h001), 2'b11);
    send_frame(1, 9'h07E, good_par(1, 9'h07E), 2'b11);
    hold(1, 1'b1, CPB);
    drain();

    // Reset in the middle of the data bits
    hold(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(0, 1'b1, CPB);
    rst = 1'b1;
    #1;
    chk("midreset_byte", 64'(byte_a), 64'd0);
    chk("midreset_flags", 64'({dv[0], perr[0], ferr[0], busy[0]}), 64'd0);
    rx[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(0, 1'b1, 2 * CPB);
    send_frame(0, 9'h0C3, good_par(0, 9'h0C3), 2'b11);
    hold(0, 1'b1, CPB);
    drain();

    // Randomised frames across all three formats
    for (int n = 0; n < 40; n++) begin
      id = int'($urandom_range(0, 2));
      d  = 9'($urandom);
      p  = good_par(id, d);
      if ($urandom_range(0, 4) == 0) p = ~p;
      st = 2'b11;
      if ($urandom_range(0, 4) == 0) st[$urandom_range(0, ns[id] - 1)] = 1'b0;
      send_frame(id, d, p, st);
      if (!st[ns[id] - 1]) hold(id, 1'b1, CPB);
      else hold(id, 1'b1, int'($urandom_range(0, 20)));
      // Frames on other lines must not overlap this one's completion
      if ($urandom_range(0, 1) == 0) drain();
    end
    hold(0, 1'b1, CPB);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
